// File: rtl/mips_pkg.sv
// mips_pkg: shared MUL encodings (sequencer state, funct field, ALUOp code)
package mips_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } mul_state_t;
   localparam logic [5:0] FUNCT_MUL = 6'b011000;
   localparam logic [3:0] ALUOP_MUL = 4'b1010;
endpackage

// File: rtl/mul_sequencer.sv
// mul_sequencer: shift-add multiplier for EX stage; MUL_EARLY_EXIT_EN ends RUN once the multiplier is exhausted
module mul_sequencer
   import mips_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Flush,
   input  logic [WIDTH-1:0] OperandA,
   input  logic [WIDTH-1:0] OperandB,
   output logic             Stall,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Result
);
   mul_state_t       state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, result_q, result_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             done_q, done_d, busy_q, busy_d;
   logic [WIDTH-1:0] acc_step;
   logic             last;
   assign acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;
`ifdef MUL_EARLY_EXIT_EN
   assign last = (count_q == CNT_W'(WIDTH - 1)) || ((mplier_q >> 1) == '0);
`else
   assign last = count_q == CNT_W'(WIDTH - 1);
`endif
   assign Stall  = (state_q == IDLE && Start && !Flush) || state_q == RUN;
   assign Busy   = busy_q;
   assign Done   = done_q;
   assign Result = result_q;
   // next-state and datapath step: accept in IDLE, one add/shift per RUN cycle
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      count_d  = count_q;
      result_d = result_q;
      case (state_q)
         IDLE: if (Start && !Flush) begin
            state_d  = RUN;
            mcand_d  = OperandA;
            mplier_d = OperandB;
            acc_d    = '0;
            count_d  = '0;
         end
         RUN: if (Flush) state_d = IDLE;
         else begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + CNT_W'(1);
            if (last) begin
               state_d  = DONE;
               result_d = acc_step;
            end
         end
         default: state_d = IDLE;
      endcase
      done_d = state_d == DONE;
      busy_d = state_d == RUN;
   end
   // state and registered outputs; reset overrides everything
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         count_q  <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         count_q  <= count_d;
         result_q <= result_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end
endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: scoreboard bench for mul_sequencer latency, results, flush and reset
module tb_mul_sequencer;
   logic        Clk = 1'b0;
   logic        Reset, Start, Flush;
   logic [31:0] OperandA, OperandB;
   logic        Stall, Busy, Done;
   logic [31:0] Result;
   int          n_run = 0, n_fail = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_res = '0;
   mul_sequencer dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Flush(Flush),
      .OperandA(OperandA), .OperandB(OperandB),
      .Stall(Stall), .Busy(Busy), .Done(Done), .Result(Result)
   );
   always #5 Clk = ~Clk;
   function automatic int exp_steps(input logic [31:0] b);
`ifdef MUL_EARLY_EXIT_EN
      for (int i = 31; i >= 0; i--) if (b[i]) return i + 1;
      return 1;
`else
      return 32;
`endif
   endfunction
   task automatic step();
      @(posedge Clk);
      #1;
   endtask
   task automatic test_reset();
      Reset = 1'b1; Start = 1'b0; Flush = 1'b0; OperandA = '0; OperandB = '0;
      step(); step();
      n_run++;
      if ({Result, Done, Busy, Stall} !== 35'd0) begin
         n_fail++;
         $display("FAIL reset: Result=%h Done=%b Busy=%b Stall=%b, required all 0", Result, Done, Busy, Stall);
      end
      Reset = 1'b0;
      step();
   endtask
   task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input bit keep_start, input string name);
      int steps, done_at, stall_err, busy_err;
      logic [31:0] expv;
      steps = exp_steps(b);
      exp_q.push_back(a * b);
      Start = 1'b1; Flush = 1'b0; OperandA = a; OperandB = b;
      done_at = -1; stall_err = 0; busy_err = 0;
      for (int k = 0; k < 40 && done_at < 0; k++) begin
         if (k > 0) begin OperandA = $urandom; OperandB = $urandom; end
         #1;
         if (Stall !== (k <= steps)) stall_err++;
         if (Busy !== (k >= 1 && k <= steps)) busy_err++;
         if (Done === 1'b1) begin
            done_at = k;
            n_run++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL %s result: Done with empty scoreboard, Result=%h", name, Result);
            end else begin
               expv = exp_q.pop_front();
               if (Result !== expv) begin
                  n_fail++;
                  $display("FAIL %s result: got %h, required %h", name, Result, expv);
               end
               last_res = expv;
            end
         end
         @(posedge Clk);
         #1;
      end
      if (done_at < 0 && exp_q.size() != 0) void'(exp_q.pop_front());
      n_run++;
      if (done_at != steps + 1) begin
         n_fail++;
         $display("FAIL %s latency: Done at T+%0d, required T+%0d", name, done_at, steps + 1);
      end
      n_run++;
      if (stall_err != 0 || busy_err != 0) begin
         n_fail++;
         $display("FAIL %s stall/busy: %0d stall and %0d busy cycles wrong, required 0", name, stall_err, busy_err);
      end
      if (!keep_start) Start = 1'b0;
   endtask
   task automatic test_basic();
      run_mul(32'd7, 32'd6, 1'b0, "mul_7x6");
      step();
      n_run++;
      if (Result !== 32'd42) begin
         n_fail++;
         $display("FAIL hold_result: got %h, required %h", Result, 32'd42);
      end
      run_mul(32'hFFFF_FFFD, 32'd5, 1'b0, "mul_neg3x5");
      step();
      run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mul_m1xm1");
      step();
      run_mul(32'd0, 32'd1234, 1'b0, "mul_zero_a");
      step();
      run_mul(32'h1234_5678, 32'd0, 1'b0, "mul_b0");
      step();
      run_mul(32'hDEAD_BEEF, 32'd1, 1'b0, "mul_b1");
      step();
      run_mul(32'h0001_2345, 32'h8000_0000, 1'b0, "mul_msb");
      step();
   endtask
   task automatic test_back_to_back();
      run_mul(32'd3, 32'd4, 1'b1, "b2b_first");
      run_mul(32'h0001_0000, 32'h0001_0000, 1'b0, "b2b_second");
      step();
   endtask
   task automatic test_random();
      for (int i = 0; i < 4; i++) begin
         run_mul($urandom, $urandom >> $urandom_range(31, 0), 1'b0, "mul_rand");
         step();
      end
   endtask
   task automatic test_flush_run();
      int dones;
      logic [31:0] prev;
      prev = last_res;
      Start = 1'b1; Flush = 1'b0; OperandA = 32'd5; OperandB = 32'h8000_0001;
      for (int k = 0; k < 10; k++) step();
      Flush = 1'b1;
      step();
      Start = 1'b0; Flush = 1'b0;
      #1;
      n_run++;
      if (Busy !== 1'b0 || Stall !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_idle: Busy=%b Stall=%b, required 0 0", Busy, Stall);
      end
      dones = 0;
      for (int k = 0; k < 40; k++) begin
         if (Done === 1'b1) dones++;
         step();
      end
      n_run++;
      if (dones != 0 || Result !== prev) begin
         n_fail++;
         $display("FAIL flush_nodone: %0d Done pulses Result=%h, required 0 and %h", dones, Result, prev);
      end
   endtask
   task automatic test_reset_mid_run();
      Start = 1'b1; Flush = 1'b0; OperandA = 32'd9; OperandB = 32'hF000_0000;
      for (int k = 0; k < 5; k++) step();
      Start = 1'b0; Reset = 1'b1;
      step();
      Reset = 1'b0;
      #1;
      n_run++;
      if (Busy !== 1'b0 || Done !== 1'b0 || Stall !== 1'b0 || Result !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_mid_run: Busy=%b Done=%b Stall=%b Result=%h, required 0 0 0 0", Busy, Done, Stall, Result);
      end
      step();
   endtask
   task automatic test_start_flush_idle();
      int bad;
      bad = 0;
      Start = 1'b1; Flush = 1'b1; OperandA = 32'd2; OperandB = 32'd3;
      for (int k = 0; k < 4; k++) begin
         #1;
         if (Stall !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) bad++;
         step();
      end
      n_run++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL start_flush_idle: %0d cycles with Stall/Busy/Done set, required 0", bad);
      end
      Start = 1'b0; Flush = 1'b0;
      step();
   endtask
   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_random();
      test_flush_run();
      test_reset_mid_run();
      test_start_flush_idle();
      run_mul(32'd11, 32'd13, 1'b0, "after_flush");
      step();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Multi-cycle shift-add multiply unit for the EX stage of the five-stage MIPS pipeline.
- Executes MUL (R-type, funct 011000, low 32 bits of the product to rd).
- Holds the pipeline with Stall while it iterates, then presents Result for one Done cycle so the instruction advances to MEM.
- Start comes from EX-stage decode (ALUOp == MUL); Flush comes from branch/jump resolution.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  EX-stage instruction is MUL; level signal, held high while stalled.
- Flush  input  1  kill the in-flight MUL (branch/jump flush).
- OperandA  input  WIDTH  rs value, sampled on the accept cycle only.
- OperandB  input  WIDTH  rt value, sampled on the accept cycle only.
- Stall  output  1  freeze PC, IF/ID and ID/EX; combinational.
- Busy  output  1  high in RUN.
- Done  output  1  one-cycle pulse; Result valid.
- Result  output  WIDTH  low WIDTH bits of OperandA*OperandB; holds until the next Done.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high. Reset has priority over all other inputs.
- Reset values: state=IDLE, acc=0, mcand=0, mplier=0, count=0, Result=0, Done=0, Busy=0, Stall=0.
- States: IDLE, RUN, DONE; encoding is in the package.
- IDLE:
  - Start=1 and Flush=0: accept. Load mcand=OperandA, mplier=OperandB, acc=0, count=0; go to RUN.
  - Start=1 and Flush=1: stay in IDLE, nothing loaded.
- RUN, one step per cycle:
  - If mplier[0], acc += mcand (modulo 2^WIDTH).
  - mcand <<= 1; mplier >>= 1; count++.
  - After the step with count==WIDTH-1, go to DONE and latch Result from the updated acc.
- Signedness: the low-word product is identical for signed and unsigned two's-complement operands, so there is no sign handling.
- DONE:
  - Done=1 for exactly this cycle; Stall=0, so the instruction moves to MEM.
  - Unconditionally return to IDLE.
  - Start is ignored here; it still reflects the same instruction.
- Stall = (IDLE & Start & ~Flush) | RUN. Low in DONE.
- Latency (feature off): accept at cycle T. RUN covers T+1..T+WIDTH. Done at T+WIDTH+1. Stall high T..T+WIDTH, i.e. WIDTH+1 stall cycles.
- Back-to-back MUL: Start high in the IDLE cycle after DONE is a new accept, with no bubble beyond that IDLE cycle.
- Flush in RUN: go to IDLE next cycle. No Done, Result unchanged, Stall drops the next cycle.
- Flush in DONE: Done still pulses; the pipeline discards it downstream.
- Reset mid-RUN: IDLE next cycle, Result cleared to 0.
- Busy = (state==RUN).

Optional Feature:
- Macro: MUL_EARLY_EXIT_EN.
- Defined: in RUN, also go to DONE after any step whose shifted mplier is 0.
  - OperandB=0 or OperandB=1 gives one RUN cycle (Done at T+2).
  - Result is bit-identical to the full iteration.
- Undefined: fixed WIDTH RUN cycles regardless of operands.

Decomposition:
- Shared package mips_pkg holds:
  - the mul_state_t encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10);
  - the MUL funct constant 6'b011000;
  - the ALUOp code for MUL, shared with the controller.
- No sub-module: the single step is one add and two shifts, inline.

Test Plan:
- Reset, then Start with A=7, B=6 accepted at T: Stall high T..T+32; Done=1 only at T+33 with Result=42; Stall=0 at T+33.
- A=0xFFFFFFFD (-3), B=5 -> Result=0xFFFFFFF1. A=0xFFFFFFFF, B=0xFFFFFFFF -> Result=0x00000001.
- Two MULs back to back, 3*4 then 0x10000*0x10000: Results 12 then 0x00000000. The second is accepted in the IDLE cycle after the first Done.
- Flush asserted at T+10 during a RUN: IDLE at T+11, Stall=0 at T+11, Done never pulses, Result keeps its previous value. Reset asserted at T+5 of another RUN: IDLE next cycle, Result=0.
- Start and Flush together in IDLE: no accept, Stall=0, Busy stays 0.
- With MUL_EARLY_EXIT_EN: A=7, B=6 -> Done at T+4, Result=42. B=0 -> Done at T+2, Result=0. Without the macro, the same operands give Done at T+33.
